// File: rtl/rf_dual_read_port.sv
// rf_dual_read_port: 16 x 32 register file for the SISC datapath.
// One write port with write-first forwarding into two registered read
// ports (A and B). Register 0 is hard-wired to zero. A read-valid flag
// and a saturating count of committed writes are also provided.
module rf_dual_read_port #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_valid,
  output logic [7:0]        wr_count
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] rd_data_a_q, rd_data_a_d;
  logic [DATA_W-1:0] rd_data_b_q, rd_data_b_d;
  logic              rd_valid_q, rd_valid_d;
  logic [7:0]        wr_count_q, wr_count_d;

  logic wr_commit_s;
  logic fwd_a_s;
  logic fwd_b_s;

  // A write only takes effect for a nonzero destination; R0 stays zero.
  assign wr_commit_s = wr_en && (wr_addr != {ADDR_W{1'b0}});
  // Forwarding compares raw addresses, so a dropped R0 write never forwards.
  assign fwd_a_s = wr_commit_s && (wr_addr == rd_addr_a);
  assign fwd_b_s = wr_commit_s && (wr_addr == rd_addr_b);

  // Storage array: cleared on reset, otherwise commits nonzero-address writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= {DATA_W{1'b0}};
      end
    end else if (wr_commit_s) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  // Next read data: R0 reads zero, same-edge write wins, else the array.
  always_comb begin
    rd_data_a_d = rd_data_a_q;
    rd_data_b_d = rd_data_b_q;
    rd_valid_d  = 1'b0;
    if (rd_en) begin
      rd_valid_d = 1'b1;
      if (rd_addr_a == {ADDR_W{1'b0}}) begin
        rd_data_a_d = {DATA_W{1'b0}};
      end else if (fwd_a_s) begin
        rd_data_a_d = wr_data;
      end else begin
        rd_data_a_d = regs_q[rd_addr_a];
      end
      if (rd_addr_b == {ADDR_W{1'b0}}) begin
        rd_data_b_d = {DATA_W{1'b0}};
      end else if (fwd_b_s) begin
        rd_data_b_d = wr_data;
      end else begin
        rd_data_b_d = regs_q[rd_addr_b];
      end
    end else begin
      rd_valid_d = 1'b0;
    end
  end

  // Next write count: one per committed write, held at 255 once saturated.
  always_comb begin
    wr_count_d = wr_count_q;
    if (wr_commit_s && (wr_count_q != 8'd255)) begin
      wr_count_d = wr_count_q + 8'd1;
    end else begin
      wr_count_d = wr_count_q;
    end
  end

  // Output registers; reset also discards any read in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_a_q <= {DATA_W{1'b0}};
      rd_data_b_q <= {DATA_W{1'b0}};
      rd_valid_q  <= 1'b0;
      wr_count_q  <= 8'd0;
    end else begin
      rd_data_a_q <= rd_data_a_d;
      rd_data_b_q <= rd_data_b_d;
      rd_valid_q  <= rd_valid_d;
      wr_count_q  <= wr_count_d;
    end
  end

  assign rd_data_a = rd_data_a_q;
  assign rd_data_b = rd_data_b_q;
  assign rd_valid  = rd_valid_q;
  assign wr_count  = wr_count_q;

endmodule

// File: doc/rf_dual_read_port.md
Name: rf_dual_read_port

Overview:
- Register-file storage block for the SISC datapath.
- It consumes the 32-bit write-back word chosen by the register-file write mux and commits it to a 16-entry array.
- It serves two independent registered read ports (A and B) to the ALU operand path.
- It is the reader/storage end of the write-back interface, with write-first forwarding and a read-valid handshake.

Parameters:
- DATA_W, 32, width of each register and of the write/read data.
- ADDR_W, 4, register address width; depth is 2**ADDR_W (16).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  write strobe; commits wr_data to wr_addr at this rising edge.
- wr_addr  input  ADDR_W  destination register.
- wr_data  input  DATA_W  write-back word (output of the write-data mux).
- rd_en  input  1  read request; samples both read addresses at this edge.
- rd_addr_a  input  ADDR_W  read port A register address.
- rd_addr_b  input  ADDR_W  read port B register address.
- rd_data_a  output  DATA_W  registered port A data.
- rd_data_b  output  DATA_W  registered port B data.
- rd_valid  output  1  high for the cycle after an accepted rd_en; both data outputs are valid.
- wr_count  output  8  saturating count of committed non-R0 writes, for the debug/test interface.

Behaviour:
- Reset (rst=1 at an edge):
  - All 16 registers clear to 0.
  - rd_data_a, rd_data_b and rd_valid clear to 0.
  - wr_count clears to 0.
  - Any wr_en or rd_en in the same cycle is ignored.
  - Reset mid-operation discards in-flight reads, so rd_valid is 0 on the next cycle.
- Register 0:
  - Reads always return 0.
  - Writes to address 0 are dropped and do not increment wr_count.
- Write:
  - With wr_en=1 at edge N, reg[wr_addr] equals wr_data after edge N.
  - Latency is one edge; there is no back-pressure, so writes are accepted every cycle.
- Read:
  - With rd_en=1 at edge N, rd_data_a/rd_data_b are loaded at edge N and rd_valid=1 during cycle N..N+1.
  - With rd_en=0 at an edge, rd_valid goes to 0 and rd_data_a/rd_data_b hold their previous values.
  - Back-to-back rd_en gives rd_valid high continuously, with fresh data every cycle.
- Simultaneous read and write to the same nonzero address at the same edge:
  - The read returns the new wr_data (write-first forwarding).
  - This applies independently to port A and port B.
  - If wr_addr=0, no forwarding occurs and the read returns 0.
- Both ports may address the same register; both return identical data.
- wr_count:
  - Increments by 1 per committed nonzero-address write.
  - Saturates at 255 and does not wrap.
- Out-of-range addresses cannot occur, since ADDR_W fully spans the array.
- X-free outputs are required after the first reset edge.
- Implementation:
  - The storage array is a reg array written in a single clocked process.
  - Forwarding compare is on the raw addresses, gated by wr_en and by wr_addr != 0.

Test Plan:
- Reset then read all: assert rst one cycle; then rd_en with A=0..15 and B=15..0 sequentially -> every rd_data_a/b = 0, rd_valid=1 each following cycle, wr_count=0.
- Write/readback: write reg3=0xDEADBEEF and reg7=0x00000001; next cycle rd_en A=3, B=7 -> rd_data_a=0xDEADBEEF, rd_data_b=0x00000001, rd_valid=1; wr_count=2.
- R0 protection: write reg0=0xFFFFFFFF, then read A=0, B=0 -> both 0, wr_count unchanged.
- Forwarding: reg5 holds 0x11111111; same edge wr_en reg5=0x22222222 and rd_en A=5, B=5 -> both ports 0x22222222. Same edge with wr_addr=0 and read A=0 -> 0.
- Hold/valid: rd_en for 3 consecutive cycles then low -> rd_valid high exactly 3 cycles; data holds last value afterward.
- Reset mid-operation and saturation: 300 writes to reg1 -> wr_count=255. Then rst concurrent with rd_en A=1 -> next cycle rd_valid=0, rd_data_a=0, reg1 reads 0 afterward, wr_count=0.
